// File: rtl/multi_code_lock_core_pkg.sv
// Shared types and key constants for the multi-digit code lock.
package multi_code_lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_UNLOCKED = 3'd1,
        ST_NEW_CODE = 3'd2,
        ST_CONFIRM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } lock_state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CHANGE = 4'hC;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_code_lock_core_if.sv
// Keypad input and lock status bundle between scanner, lock core and status display.
interface multi_code_lock_core_if #(
    parameter int unsigned DIGITS = 4
);
    import multi_code_lock_pkg::*;

    logic                         key_valid;
    logic [3:0]                   key_code;
    logic                         unlocked;
    logic                         locked_out;
    lock_state_t                  state;
    logic [4*DIGITS-1:0]          entry;
    logic [$clog2(DIGITS+1)-1:0]  entry_count;
    logic [3:0]                   tries_left;
    logic                         ok_pulse;
    logic                         err_pulse;

    modport master (
        output key_valid, key_code,
        input  unlocked, locked_out, state, entry, entry_count, tries_left, ok_pulse, err_pulse
    );

    modport slave (
        input  key_valid, key_code,
        output unlocked, locked_out, state, entry, entry_count, tries_left, ok_pulse, err_pulse
    );

endinterface

// File: rtl/multi_code_lock_core_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. on the last timed cycle.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/multi_code_lock_core.sv
// Keypad code lock: entry shift register, code/temp registers, attempt counter and one shared timer.
module multi_code_lock_core
    import multi_code_lock_pkg::*;
#(
    parameter int unsigned         DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned         MAX_TRIES      = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 125_000_000,
    parameter int unsigned         UNLOCK_CYCLES  = 625_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_code_lock_core_if.slave   bus
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(max_u(LOCKOUT_CYCLES, UNLOCK_CYCLES) + 1);

    lock_state_t   state, state_n;
    logic [DW-1:0] entry, entry_n, code, code_n, temp, temp_n;
    logic [CW-1:0] entry_count, count_n;
    logic [3:0]    tries_left, tries_n;
    logic          ok_q, err_q, ok_n, err_n;
    logic          unlocked_q, locked_out_q;
    logic          t_load, t_done;
    logic [TW-1:0] t_val;
    logic          full;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    assign full = (entry_count == CW'(DIGITS));

    always_comb begin
        state_n = state;
        entry_n = entry;
        count_n = entry_count;
        code_n  = code;
        temp_n  = temp;
        tries_n = tries_left;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        t_load  = 1'b0;
        t_val   = '0;

        // Expiry wins over a key arriving on the same cycle.
        if (t_done) begin
            state_n = ST_LOCKED;
            entry_n = '0;
            count_n = '0;
            if (state == ST_LOCKOUT)
                tries_n = 4'(MAX_TRIES);
            else
                temp_n = '0;
        end else if (bus.key_valid && state != ST_LOCKOUT) begin
            if (state != ST_LOCKED) begin
                t_load = 1'b1;
                t_val  = TW'(UNLOCK_CYCLES);
            end
            if (bus.key_code <= 4'h9) begin
                if (!full) begin
                    entry_n = (entry << 4) | DW'(bus.key_code);
                    count_n = entry_count + CW'(1);
                end
            end else if (bus.key_code == KEY_CLEAR) begin
                entry_n = '0;
                count_n = '0;
            end else if (bus.key_code == KEY_CHANGE) begin
                if (state == ST_UNLOCKED)
                    state_n = ST_NEW_CODE;
            end else if (bus.key_code == KEY_ENTER) begin
                entry_n = '0;
                count_n = '0;
                case (state)
                    ST_LOCKED: begin
                        if (full && entry == code) begin
                            ok_n    = 1'b1;
                            state_n = ST_UNLOCKED;
                            tries_n = 4'(MAX_TRIES);
                            t_load  = 1'b1;
                            t_val   = TW'(UNLOCK_CYCLES);
                        end else begin
                            err_n = 1'b1;
                            if (tries_left <= 4'd1) begin
                                tries_n = '0;
                                state_n = ST_LOCKOUT;
                                t_load  = 1'b1;
                                t_val   = TW'(LOCKOUT_CYCLES);
                            end else begin
                                tries_n = tries_left - 4'd1;
                            end
                        end
                    end
                    ST_UNLOCKED: begin
                        state_n = ST_LOCKED;
                        t_val   = '0;
                    end
                    ST_NEW_CODE: begin
                        if (full) begin
                            temp_n  = entry;
                            state_n = ST_CONFIRM;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (full && entry == temp) begin
                            code_n = temp;
                            ok_n   = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                        temp_n  = '0;
                        state_n = ST_UNLOCKED;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_LOCKED;
            entry        <= '0;
            entry_count  <= '0;
            code         <= DEFAULT_CODE;
            temp         <= '0;
            tries_left   <= 4'(MAX_TRIES);
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state        <= state_n;
            entry        <= entry_n;
            entry_count  <= count_n;
            code         <= code_n;
            temp         <= temp_n;
            tries_left   <= tries_n;
            ok_q         <= ok_n;
            err_q        <= err_n;
            unlocked_q   <= (state_n == ST_UNLOCKED) || (state_n == ST_NEW_CODE) ||
                            (state_n == ST_CONFIRM);
            locked_out_q <= (state_n == ST_LOCKOUT);
        end
    end

    assign bus.state       = state;
    assign bus.entry       = entry;
    assign bus.entry_count = entry_count;
    assign bus.tries_left  = tries_left;
    assign bus.ok_pulse    = ok_q;
    assign bus.err_pulse   = err_q;
    assign bus.unlocked    = unlocked_q;
    assign bus.locked_out  = locked_out_q;

endmodule

// File: tb/tb_multi_code_lock_core.sv
// Directed bench for multi_code_lock_core: vector table plus timed and code-change sequences.
module tb_multi_code_lock_core;
    import multi_code_lock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multi_code_lock_core_if #(.DIGITS(4)) bus ();

    multi_code_lock_core #(
        .DIGITS         (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (100),
        .UNLOCK_CYCLES  (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        lock_state_t st;
        logic [15:0] e;
        logic [2:0]  c;
        logic [3:0]  t;
        logic        ok;
        logic        err;
    } vec_t;

    vec_t vq[$];

    localparam lock_state_t L  = ST_LOCKED;
    localparam lock_state_t U  = ST_UNLOCKED;
    localparam lock_state_t N  = ST_NEW_CODE;
    localparam lock_state_t CF = ST_CONFIRM;
    localparam lock_state_t LO = ST_LOCKOUT;

    task automatic add(input logic kv, input logic [3:0] key, input lock_state_t st,
                       input logic [15:0] e, input logic [2:0] c, input logic [3:0] t,
                       input logic ok, input logic err);
        vq.push_back('{kv, key, st, e, c, t, ok, err});
    endtask

    task automatic step(input logic v, input logic [3:0] k);
        bus.key_valid = v;
        bus.key_code  = k;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic digits4(input logic [15:0] d);
        for (int i = 3; i >= 0; i--) step(1'b1, d[i*4 +: 4]);
    endtask

    task automatic chk(input string name, input lock_state_t st, input logic [15:0] e,
                       input logic [2:0] c, input logic [3:0] t, input logic ok, input logic err);
        logic eu, elo;
        eu  = (st == U) || (st == N) || (st == CF);
        elo = (st == LO);
        n_vec++;
        if (bus.state !== st || bus.entry !== e || bus.entry_count !== c ||
            bus.tries_left !== t || bus.ok_pulse !== ok || bus.err_pulse !== err ||
            bus.unlocked !== eu || bus.locked_out !== elo) begin
            n_err++;
            $display("FAIL %s: got st=%0d entry=%h cnt=%0d tries=%0d ok=%b err=%b unl=%b lo=%b, expected st=%0d entry=%h cnt=%0d tries=%0d ok=%b err=%b unl=%b lo=%b",
                     name, bus.state, bus.entry, bus.entry_count, bus.tries_left,
                     bus.ok_pulse, bus.err_pulse, bus.unlocked, bus.locked_out,
                     st, e, c, t, ok, err, eu, elo);
        end
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;

        add(0, 4'h0, L, 16'h0000, 0, 3, 0, 0);
        add(1, 4'h1, L, 16'h0001, 1, 3, 0, 0);
        add(1, 4'h2, L, 16'h0012, 2, 3, 0, 0);
        add(1, 4'h3, L, 16'h0123, 3, 3, 0, 0);
        add(1, 4'h4, L, 16'h1234, 4, 3, 0, 0);
        add(1, 4'hB, U, 16'h0000, 0, 3, 1, 0);
        add(0, 4'h0, U, 16'h0000, 0, 3, 0, 0);
        add(1, 4'hD, U, 16'h0000, 0, 3, 0, 0);
        add(1, 4'h9, U, 16'h0009, 1, 3, 0, 0);
        add(1, 4'hA, U, 16'h0000, 0, 3, 0, 0);
        add(1, 4'hB, L, 16'h0000, 0, 3, 0, 0);
        add(1, 4'hC, L, 16'h0000, 0, 3, 0, 0);
        add(1, 4'h1, L, 16'h0001, 1, 3, 0, 0);
        add(1, 4'h2, L, 16'h0012, 2, 3, 0, 0);
        add(1, 4'hB, L, 16'h0000, 0, 2, 0, 1);
        add(1, 4'h1, L, 16'h0001, 1, 2, 0, 0);
        add(1, 4'h2, L, 16'h0012, 2, 2, 0, 0);
        add(1, 4'h3, L, 16'h0123, 3, 2, 0, 0);
        add(1, 4'h4, L, 16'h1234, 4, 2, 0, 0);
        add(1, 4'h5, L, 16'h1234, 4, 2, 0, 0);
        add(1, 4'hA, L, 16'h0000, 0, 2, 0, 0);
        add(1, 4'h9, L, 16'h0009, 1, 2, 0, 0);
        add(1, 4'h9, L, 16'h0099, 2, 2, 0, 0);
        add(1, 4'h9, L, 16'h0999, 3, 2, 0, 0);
        add(1, 4'h9, L, 16'h9999, 4, 2, 0, 0);
        add(1, 4'hB, L, 16'h0000, 0, 1, 0, 1);
        add(1, 4'h1, L, 16'h0001, 1, 1, 0, 0);
        add(1, 4'h2, L, 16'h0012, 2, 1, 0, 0);
        add(1, 4'h3, L, 16'h0123, 3, 1, 0, 0);
        add(1, 4'h4, L, 16'h1234, 4, 1, 0, 0);
        add(1, 4'hB, U, 16'h0000, 0, 3, 1, 0);
        add(1, 4'hB, L, 16'h0000, 0, 3, 0, 0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].kv, vq[i].key);
            chk($sformatf("vec%0d", i), vq[i].st, vq[i].e, vq[i].c, vq[i].t, vq[i].ok, vq[i].err);
        end

        // Three wrong codes force lockout; keys are ignored for exactly 100 cycles.
        for (int a = 0; a < 3; a++) begin
            digits4(16'h9999);
            step(1'b1, KEY_ENTER);
            if (a < 2) chk("wrong_code", L, 16'h0, 0, 4'(2 - a), 0, 1);
            else       chk("lockout_entry", LO, 16'h0, 0, 0, 0, 1);
        end
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 4'h1);
            if (i < 100) chk("lockout_dwell", LO, 16'h0, 0, 0, 0, 0);
            else         chk("lockout_expiry", L, 16'h0, 0, 3, 0, 0);
        end

        // Idle re-lock after 50 cycles.
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("unlock_idle", U, 16'h0, 0, 3, 1, 0);
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 4'h0);
            if (i == 49 || i == 50) chk("idle_timeout", (i < 50) ? U : L, 16'h0, 0, 3, 0, 0);
        end

        // Key activity at cycle 40 pushes re-lock out to cycle 90.
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("unlock_idle2", U, 16'h0, 0, 3, 1, 0);
        for (int i = 1; i <= 90; i++) begin
            step(i == 40, 4'hD);
            if (i == 50 || i == 89 || i == 90) chk("idle_reload", (i < 90) ? U : L, 16'h0, 0, 3, 0, 0);
        end

        // Mismatched confirm leaves the code at 1234.
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("unlock_cc", U, 16'h0, 0, 3, 1, 0);
        step(1'b1, KEY_CHANGE);
        chk("enter_new_code", N, 16'h0, 0, 3, 0, 0);
        digits4(16'h5678);
        chk("new_code_entry", N, 16'h5678, 4, 3, 0, 0);
        step(1'b1, KEY_ENTER);
        chk("to_confirm", CF, 16'h0, 0, 3, 0, 0);
        digits4(16'h5679);
        step(1'b1, KEY_ENTER);
        chk("confirm_mismatch", U, 16'h0, 0, 3, 0, 1);
        step(1'b1, KEY_ENTER);
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("old_code_kept", U, 16'h0, 0, 3, 1, 0);

        // Successful change to 5678.
        step(1'b1, KEY_CHANGE);
        digits4(16'h5678);
        step(1'b1, KEY_ENTER);
        digits4(16'h5678);
        step(1'b1, KEY_ENTER);
        chk("change_ok", U, 16'h0, 0, 3, 1, 0);
        step(1'b1, KEY_ENTER);
        chk("relock", L, 16'h0, 0, 3, 0, 0);
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("old_code_rejected", L, 16'h0, 0, 2, 0, 1);
        digits4(16'h5678);
        step(1'b1, KEY_ENTER);
        chk("new_code_accepted", U, 16'h0, 0, 3, 1, 0);

        // Short entry in NEW_CODE, then reset while in CONFIRM.
        step(1'b1, KEY_CHANGE);
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, KEY_ENTER);
        chk("new_code_short", N, 16'h0, 0, 3, 0, 1);
        digits4(16'h1111);
        step(1'b1, KEY_ENTER);
        chk("confirm_before_rst", CF, 16'h0, 0, 3, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", L, 16'h0, 0, 3, 0, 0);
        #1 rst = 1'b0;
        digits4(16'h1234);
        step(1'b1, KEY_ENTER);
        chk("default_code_after_rst", U, 16'h0, 0, 3, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_code_lock_core.md
# multi_code_lock_core

Parametrised successor to the lock FSM. It accepts a stream of decoded keypad keys and holds a `DIGITS`-digit BCD code. It counts failed attempts and, after `MAX_TRIES` consecutive failures, forces a timed lockout. It also re-locks automatically after an idle timeout and supports an in-field code change with double entry. It sits between the keypad scanner (key/keypress) and the LED/RGB/SSD status controller; the entry buffer drives the SSD digits.

## Interface
Parameters:
- `DIGITS`, 4: code length in BCD digits (1–8).
- `DEFAULT_CODE`, `16'h1234`: code loaded at reset; width `4*DIGITS`.
- `MAX_TRIES`, 3: consecutive failed attempts before lockout (1–15).
- `LOCKOUT_CYCLES`, 125_000_000: lockout duration in `clk` cycles.
- `UNLOCK_CYCLES`, 625_000_000: idle cycles in UNLOCKED before auto re-lock.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid this cycle.
- `key_code` in 4: 0x0–0x9 digit, 0xA clear, 0xB enter, 0xC change-code; 0xD–0xF ignored.
- `unlocked` out 1: high in UNLOCKED, NEW_CODE and CONFIRM.
- `locked_out` out 1: high in LOCKOUT.
- `state` out 3: current state encoding (package enum).
- `entry` out `4*DIGITS`: entry buffer; newest digit in bits [3:0].
- `entry_count` out `$clog2(DIGITS+1)`: digits currently held.
- `tries_left` out 4: remaining attempts.
- `ok_pulse` out 1: one-cycle pulse on accepted code or completed code change.
- `err_pulse` out 1: one-cycle pulse on wrong code, short entry or confirm mismatch.

## Operation
- States:
  - LOCKED: reset state.
  - UNLOCKED.
  - NEW_CODE.
  - CONFIRM.
  - LOCKOUT.
- Digit key: shift `entry` left 4 bits, insert the digit, increment `entry_count`. If `entry_count==DIGITS`, the digit is ignored; there is no wrap.
- Clear (0xA): `entry` and `entry_count` go to 0 in any state except LOCKOUT.
- Enter (0xB) in LOCKED:
  - Short entry (`entry_count<DIGITS`): err_pulse; counts as a failed attempt.
  - `entry==code`: ok_pulse, go to UNLOCKED, `tries_left` reloads to `MAX_TRIES`.
  - Mismatch: err_pulse, decrement `tries_left`. When it reaches 0, go to LOCKOUT and load the timer with `LOCKOUT_CYCLES`.
  - Every enter clears the entry buffer.
- UNLOCKED:
  - Enter: re-locks (go to LOCKED).
  - Change-code (0xC): go to NEW_CODE.
  - Any key_valid reloads the idle timer with `UNLOCK_CYCLES`. Timer expiry re-locks.
- NEW_CODE: a full entry followed by enter latches a temporary code and goes to CONFIRM. A short entry gives err_pulse and stays in NEW_CODE.
- CONFIRM: enter with `entry==temp`: `code<=temp`, ok_pulse, go to UNLOCKED. Otherwise err_pulse, go to UNLOCKED, code unchanged.
- NEW_CODE and CONFIRM share the UNLOCKED idle timeout. Expiry goes to LOCKED and discards the temporary code.
- LOCKOUT: all keys ignored. On timer expiry go to LOCKED, `tries_left<=MAX_TRIES`, buffer cleared.
- Change-code outside UNLOCKED and codes 0xD–0xF: no effect.

## Timing
- Reset values:
  - state LOCKED; `code=DEFAULT_CODE`; `entry=0`; `entry_count=0`.
  - `tries_left=MAX_TRIES`; `unlocked=0`; `locked_out=0`; both pulses 0; timer 0.
- Every output is registered. A key sampled at edge N is reflected in all outputs after edge N; latency is 1 cycle.
- ok_pulse and err_pulse are exactly 1 cycle wide and are never asserted together.
- Timer: loaded on entry to LOCKOUT/UNLOCKED and on key activity, then decrements every cycle. The transition fires on the cycle the count reaches 0, so the state dwells for exactly the programmed number of cycles.
- A `key_valid` on the timer-expiry cycle is dropped. Expiry wins.
- Back-to-back `key_valid` on consecutive cycles must each be processed.
- `rst` asserted mid-operation: immediate return to reset values, including code reverting to `DEFAULT_CODE`.

## Structure
- Package `multi_code_lock_pkg` holds:
  - `lock_state_t` enum (3 bits).
  - Key constants `KEY_CLEAR`, `KEY_ENTER`, `KEY_CHANGE`.
- Sub-module `lock_timer`: a loadable down-counter with a `done` pulse, sized `$clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1)`. One instance is shared by LOCKOUT and the idle timeout.
- The top of this module is one FSM plus the entry shift register and the code/temp registers.

## Test plan
Bench parameters: `DIGITS=4`, `DEFAULT_CODE=16'h1234`, `MAX_TRIES=3`, `LOCKOUT_CYCLES=100`, `UNLOCK_CYCLES=50`.
- Keys 1,2,3,4,B → ok_pulse one cycle after B; `unlocked=1`; `tries_left=3`; `entry_count=0`.
- Keys 9,9,9,9,B three times → err_pulse ×3; `locked_out=1` after the third; keys ignored for 100 cycles; then LOCKED with `tries_left=3`.
- Keys 1,2,B (short entry) → err_pulse; `tries_left=2`. Keys 1,2,3,4,5 → `entry=16'h2345` is not expected; the fifth digit is ignored, so `entry=16'h1234`.
- Unlocked, then C,5,6,7,8,B,5,6,7,8,B → ok_pulse; then B; then 5,6,7,8,B → unlocked. A confirm of 5,6,7,9 instead gives err_pulse and the code stays `1234`.
- Unlocked with no keys for 50 cycles → LOCKED on cycle 50. A key at cycle 40 pushes re-lock to cycle 90.
- `rst` pulsed during CONFIRM after a code change to 5678 → LOCKED; code=1234.
